// File: rtl/z80_bus_bridge.sv
// z80_bus_bridge: turns the tv80s level-type bus controls into single-cycle
// synchronous memory / I/O strobes with programmable wait states and a
// registered read-data return path.
//
// Optional build macro: ROM_PROTECT_EN
//   defined   -> memory writes to addresses <= ROM_TOP are suppressed and
//                rom_viol pulses in their strobe cycle instead.
//   undefined -> every write reaches memory and rom_viol stays 0.
//
// Bus cycle protocol (CPU side is level based, memory/I/O side is pulse based):
//   A CPU request is "active" while (mreq_n or iorq_n is low) and exactly one
//   of rd_n / wr_n is low. A bus cycle starts on the rising edge of that
//   active level while idle (T0). wait_n is pulled low for WAIT_STATES + 2
//   cycles (T0+1 .. T0+WS+2), the single strobe fires at T0+WS+1, read data
//   is sampled one cycle after the strobe and is presented on cpu_din from
//   T0+WS+3. Read data from memory/I/O must be valid exactly one cycle after
//   its read strobe. The request has to drop before another cycle can start,
//   so a long-held control never produces a second strobe.
module z80_bus_bridge #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] ROM_TOP     = 16'h07FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  output logic        wait_n,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_dout,
  output logic        io_rd,
  output logic        io_wr,
  input  logic [7:0]  io_din,
  output logic        rom_viol
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_LATCH  = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  localparam logic [3:0] WS = WAIT_STATES[3:0];

`ifdef ROM_PROTECT_EN
  localparam logic ROM_PROT = 1'b1;
`else
  localparam logic ROM_PROT = 1'b0;
`endif

  logic [2:0] state;
  logic [3:0] wait_cnt;
  logic       act;
  logic       act_q;
  logic       start;
  logic       lat_io;
  logic       lat_wr;
  logic       strobe;
  logic       rom_hit;

  assign act   = (~mreq_n | ~iorq_n) & (rd_n ^ wr_n);
  assign start = act & ~act_q & (state == S_IDLE);

  // Previous-cycle request level for edge detection. It also tracks through
  // reset, so a request still held when reset is released cannot restart.
  always_ff @(posedge clk) begin
    act_q <= act;
  end

  // Bus-cycle sequencer: latches the request at T0 and steps through the
  // wait / strobe / data-capture phases, then holds until the request drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      cpu_din  <= 8'hFF;
      mem_addr <= 16'h0000;
      mem_din  <= 8'h00;
      io_addr  <= 8'h00;
      io_dout  <= 8'h00;
      lat_io   <= 1'b0;
      lat_wr   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (!mreq_n) begin
              // Memory space wins when both requests are low.
              mem_addr <= A;
              mem_din  <= cpu_dout;
              lat_io   <= 1'b0;
              lat_wr   <= ~wr_n;
              wait_cnt <= WS - 4'd1;
              state    <= (WS != 4'd0) ? S_WAIT : S_STROBE;
            end else if (!m1_n) begin
              // Interrupt acknowledge: no strobe, the CPU reads a floating bus.
              cpu_din <= 8'hFF;
              state   <= S_HOLD;
            end else begin
              io_addr  <= A[7:0];
              io_dout  <= cpu_dout;
              lat_io   <= 1'b1;
              lat_wr   <= ~wr_n;
              wait_cnt <= WS - 4'd1;
              state    <= (WS != 4'd0) ? S_WAIT : S_STROBE;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_STROBE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_STROBE: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          if (!lat_wr) begin
            cpu_din <= lat_io ? io_din : mem_dout;
          end
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (!act) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes are decoded purely from state so they can never stretch.
  always_comb begin
    strobe   = (state == S_STROBE);
    rom_hit  = ROM_PROT & ~lat_io & lat_wr & (mem_addr <= ROM_TOP);
    wait_n   = ~((state == S_WAIT) | (state == S_STROBE) | (state == S_LATCH));
    mem_rd   = strobe & ~lat_io & ~lat_wr;
    mem_wr   = strobe & ~lat_io &  lat_wr & ~rom_hit;
    io_rd    = strobe &  lat_io & ~lat_wr;
    io_wr    = strobe &  lat_io &  lat_wr;
    rom_viol = strobe & rom_hit;
  end

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Testbench for z80_bus_bridge. Three bridges with WAIT_STATES = 0, 1 and 3
// share one CPU-side stimulus; each scenario checks one of them cycle by cycle
// against a reference timing model through an expected-value queue.
module tb_z80_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a;
  logic [7:0]  cpu_dout;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n;

  logic [7:0]  cpu_din_v  [3];
  logic        wait_n_v   [3];
  logic [15:0] mem_addr_v [3];
  logic [7:0]  mem_din_v  [3];
  logic        mem_rd_v   [3];
  logic        mem_wr_v   [3];
  logic [7:0]  mem_dout_v [3];
  logic [7:0]  io_addr_v  [3];
  logic [7:0]  io_dout_v  [3];
  logic        io_rd_v    [3];
  logic        io_wr_v    [3];
  logic [7:0]  io_din_v   [3];
  logic        rom_viol_v [3];

  logic [7:0]  mem_data;
  logic [7:0]  io_data;
  logic [7:0]  din_model;

  // {wait_n, mem_rd, mem_wr, io_rd, io_wr, rom_viol, cpu_din}
  logic [13:0] exp_q[$];
  int          vectors;
  int          miscompares;

`ifdef ROM_PROTECT_EN
  localparam bit ROM_ON = 1'b1;
`else
  localparam bit ROM_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    z80_bus_bridge #(.WAIT_STATES((g == 2) ? 3 : g), .ROM_TOP(16'h07FF)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .A        (a),
      .cpu_dout (cpu_dout),
      .cpu_din  (cpu_din_v[g]),
      .mreq_n   (mreq_n),
      .iorq_n   (iorq_n),
      .rd_n     (rd_n),
      .wr_n     (wr_n),
      .m1_n     (m1_n),
      .wait_n   (wait_n_v[g]),
      .mem_addr (mem_addr_v[g]),
      .mem_din  (mem_din_v[g]),
      .mem_rd   (mem_rd_v[g]),
      .mem_wr   (mem_wr_v[g]),
      .mem_dout (mem_dout_v[g]),
      .io_addr  (io_addr_v[g]),
      .io_dout  (io_dout_v[g]),
      .io_rd    (io_rd_v[g]),
      .io_wr    (io_wr_v[g]),
      .io_din   (io_din_v[g]),
      .rom_viol (rom_viol_v[g])
    );
  end

  // Memory / I/O models: data valid only in the cycle after a read strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      mem_dout_v[i] <= mem_rd_v[i] ? mem_data : 8'h00;
      io_din_v[i]   <= io_rd_v[i]  ? io_data  : 8'h00;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [13:0] model(input int ws, input bit io, input bit wr,
                                        input bit inta, input bit rom,
                                        input logic [7:0] data, input logic [7:0] prev,
                                        input int k);
    logic wn, stb;
    logic [7:0] din;
    if (inta) return {1'b1, 5'b00000, (k >= 1) ? 8'hFF : prev};
    wn  = !(k >= 1 && k <= ws + 2);
    stb = (k == ws + 1);
    din = (!wr && k >= ws + 3) ? data : prev;
    return {wn, stb & !io & !wr, stb & !io & wr & !rom, stb & io & !wr,
            stb & io & wr, stb & !io & wr & rom, din};
  endfunction

  function automatic logic [13:0] obs(input int i);
    return {wait_n_v[i], mem_rd_v[i], mem_wr_v[i], io_rd_v[i], io_wr_v[i],
            rom_viol_v[i], cpu_din_v[i]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_bus(input logic [15:0] addr, input logic [7:0] d,
                           input logic mq, input logic iq, input logic r,
                           input logic w, input logic m1);
    a = addr; cpu_dout = d; mreq_n = mq; iorq_n = iq; rd_n = r; wr_n = w; m1_n = m1;
  endtask

  task automatic idle_bus();
    drive_bus(16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic settle();
    idle_bus();
    repeat (8) step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_bus();
    repeat (3) step();
    reset = 1'b0;
    step();
    din_model = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs(i) !== {1'b1, 5'b00000, 8'hFF}) begin
        miscompares++;
        $display("FAIL reset_outputs dut=%0d got=%h exp=%h", i, obs(i), {1'b1, 5'b00000, 8'hFF});
      end
      vectors++;
      if ({mem_addr_v[i], mem_din_v[i], io_addr_v[i], io_dout_v[i]} !== 40'h0) begin
        miscompares++;
        $display("FAIL reset_latches dut=%0d got=%h exp=0", i,
                 {mem_addr_v[i], mem_din_v[i], io_addr_v[i], io_dout_v[i]});
      end
    end
    vectors++;
    if (g_dut[1].u_dut.state !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_state got=%0d exp=0", g_dut[1].u_dut.state);
    end
  endtask

  task automatic test_mem_read();
    logic [13:0] got, exp;
    mem_data = 8'hA5;
    drive_bus(16'h1234, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k <= 7; k++) exp_q.push_back(model(1, 0, 0, 0, 0, 8'hA5, din_model, k));
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) step();
      got = obs(1); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL mem_read k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 2) begin
        vectors++;
        if (mem_addr_v[1] !== 16'h1234) begin
          miscompares++;
          $display("FAIL mem_read_addr got=%h exp=1234", mem_addr_v[1]);
        end
      end
      if (k == 5) idle_bus();
    end
    din_model = 8'hA5;
    settle();
  endtask

  task automatic test_mem_write_held();
    logic [13:0] got, exp;
    drive_bus(16'h8000, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k <= 15; k++)
      exp_q.push_back((k < 11) ? model(0, 0, 1, 0, 0, 8'h00, din_model, k)
                               : model(0, 0, 1, 0, 0, 8'h00, din_model, k - 11));
    for (int k = 0; k <= 15; k++) begin
      if (k > 0) step();
      got = obs(0); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL mem_write_held k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 5) begin
        vectors++;
        if ({mem_addr_v[0], mem_din_v[0]} !== {16'h8000, 8'h3C}) begin
          miscompares++;
          $display("FAIL mem_write_latch got=%h exp=80003c", {mem_addr_v[0], mem_din_v[0]});
        end
      end
      if (k == 10) idle_bus();
      if (k == 11) drive_bus(16'h8001, 8'h3D, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    end
    vectors++;
    if ({mem_addr_v[0], mem_din_v[0]} !== {16'h8001, 8'h3D}) begin
      miscompares++;
      $display("FAIL mem_write_relatch got=%h exp=80013d", {mem_addr_v[0], mem_din_v[0]});
    end
    settle();
  endtask

  task automatic test_rom_write();
    logic [13:0] got, exp;
    drive_bus(16'h0100, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k <= 4; k++) exp_q.push_back(model(0, 0, 1, 0, ROM_ON, 8'h00, din_model, k));
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) step();
      got = obs(0); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL rom_write k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 3) idle_bus();
    end
    settle();
  endtask

  task automatic test_io_read();
    logic [13:0] got, exp;
    io_data = 8'hC3;
    drive_bus(16'h4412, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k <= 5; k++) exp_q.push_back(model(0, 1, 0, 0, 0, 8'hC3, din_model, k));
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) step();
      got = obs(0); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL io_read k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 1) begin
        vectors++;
        if (io_addr_v[0] !== 8'h12) begin
          miscompares++;
          $display("FAIL io_read_addr got=%h exp=12", io_addr_v[0]);
        end
      end
      if (k == 4) idle_bus();
    end
    din_model = 8'hC3;
    settle();
  endtask

  task automatic test_io_write_inta();
    logic [13:0] got, exp;
    drive_bus(16'h00FE, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k <= 5; k++) exp_q.push_back(model(1, 1, 1, 0, 0, 8'h00, din_model, k));
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) step();
      got = obs(1); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL io_write k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 4) idle_bus();
    end
    vectors++;
    if ({io_addr_v[1], io_dout_v[1]} !== 16'hFE07) begin
      miscompares++;
      $display("FAIL io_write_latch got=%h exp=fe07", {io_addr_v[1], io_dout_v[1]});
    end
    settle();
    drive_bus(16'h0038, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k <= 5; k++) exp_q.push_back(model(1, 1, 0, 1, 0, 8'h00, din_model, k));
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) step();
      got = obs(1); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL int_ack k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 3) idle_bus();
    end
    din_model = 8'hFF;
    settle();
  endtask

  task automatic test_early_drop();
    logic [13:0] got, exp;
    mem_data = 8'h5C;
    drive_bus(16'h3000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k <= 9; k++) exp_q.push_back(model(3, 0, 0, 0, 0, 8'h5C, din_model, k));
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) step();
      got = obs(2); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL early_drop k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 1) idle_bus();
    end
    vectors++;
    if (g_dut[2].u_dut.state !== 3'd0) begin
      miscompares++;
      $display("FAIL early_drop_state got=%0d exp=0", g_dut[2].u_dut.state);
    end
    din_model = 8'h5C;
    settle();
  endtask

  task automatic test_reset_abort();
    logic [13:0] got, exp;
    mem_data = 8'h99;
    drive_bus(16'h4000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k <= 10; k++)
      exp_q.push_back((k < 3) ? model(3, 0, 0, 0, 0, 8'h99, din_model, k)
                              : {1'b1, 5'b00000, 8'hFF});
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) step();
      got = obs(2); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_abort k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k >= 3) begin
        vectors++;
        if ({g_dut[2].u_dut.state, mem_addr_v[2]} !== 19'h0) begin
          miscompares++;
          $display("FAIL reset_abort_state k=%0d got=%h exp=0", k,
                   {g_dut[2].u_dut.state, mem_addr_v[2]});
        end
      end
      if (k == 2) reset = 1'b1;
      if (k == 3) reset = 1'b0;
    end
    din_model = 8'hFF;
    settle();
  endtask

  task automatic test_back_to_back();
    logic [13:0] got, exp;
    mem_data = 8'h11;
    drive_bus(16'h2000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k <= 11; k++)
      exp_q.push_back((k < 5) ? model(1, 0, 0, 0, 0, 8'h11, din_model, k)
                              : model(1, 0, 0, 0, 0, 8'h22, 8'h11, k - 5));
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) step();
      got = obs(1); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL back_to_back k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 4) idle_bus();
      if (k == 5) begin
        mem_data = 8'h22;
        drive_bus(16'h2001, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      end
    end
    vectors++;
    if (mem_addr_v[1] !== 16'h2001) begin
      miscompares++;
      $display("FAIL back_to_back_addr got=%h exp=2001", mem_addr_v[1]);
    end
    settle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    mem_data = 8'h00;
    io_data = 8'h00;
    din_model = 8'hFF;
    idle_bus();
    @(negedge clk);
    test_reset();
    test_mem_read();
    test_mem_write_held();
    test_rom_write();
    test_io_read();
    test_io_write_inta();
    test_early_drop();
    test_reset_abort();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
